// File: rtl/single_argmax_stream.sv
// Streaming argmax over IEEE-754 single-precision beats. It reports the first-occurrence index of the largest value.
// The result is held on a valid/ready output until downstream takes it.
module single_argmax_stream #(
  parameter int N_MAX = 1024,
  parameter int IDX_W = $clog2(N_MAX)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_max,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W:0]    out_count,
  output logic              out_overflow
);

  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [IDX_W:0] CountMax = (IDX_W+1)'(N_MAX);

  state_e             state_q, state_d;
  logic [31:0]        best_q, best_d;
  logic [IDX_W-1:0]   bestIdx_q, bestIdx_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               seenFirst_q, seenFirst_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        outMax_q, outMax_d;
  logic [IDX_W-1:0]   outIdx_q, outIdx_d;
  logic [IDX_W:0]     outCount_q, outCount_d;
  logic               outOvf_q, outOvf_d;
  logic               accept;

  // Strict "a > b" on raw float bits; NaN and Inf are ordered purely by their encoding.
  function automatic logic fpGreater(input logic [31:0] a, input logic [31:0] b);
    logic result;
    if (a[31] != b[31]) begin
      result = ~a[31];
    end else if (!a[31]) begin
      result = (a[30:0] > b[30:0]);
    end else begin
      result = (a[30:0] < b[30:0]);
    end
    return result;
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  // Beats past N_MAX are still consumed so the vector drains, but they only mark overflow.
  always_comb begin
    best_d      = best_q;
    bestIdx_d   = bestIdx_q;
    count_d     = count_q;
    seenFirst_d = seenFirst_q;
    ovf_d       = ovf_q;
    outMax_d    = outMax_q;
    outIdx_d    = outIdx_q;
    outCount_d  = outCount_q;
    outOvf_d    = outOvf_q;
    if (accept) begin
      if (count_q < CountMax) begin
        if (!seenFirst_q || fpGreater(in_data, best_q)) begin
          best_d    = in_data;
          bestIdx_d = count_q[IDX_W-1:0];
        end
        count_d     = count_q + 1'b1;
        seenFirst_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
      if (in_last) begin
        outMax_d    = best_d;
        outIdx_d    = bestIdx_d;
        outCount_d  = count_d;
        outOvf_d    = ovf_d;
        count_d     = '0;
        seenFirst_d = 1'b0;
        ovf_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      best_q      <= '0;
      bestIdx_q   <= '0;
      count_q     <= '0;
      seenFirst_q <= 1'b0;
      ovf_q       <= 1'b0;
      outMax_q    <= '0;
      outIdx_q    <= '0;
      outCount_q  <= '0;
      outOvf_q    <= 1'b0;
    end else begin
      best_q      <= best_d;
      bestIdx_q   <= bestIdx_d;
      count_q     <= count_d;
      seenFirst_q <= seenFirst_d;
      ovf_q       <= ovf_d;
      outMax_q    <= outMax_d;
      outIdx_q    <= outIdx_d;
      outCount_q  <= outCount_d;
      outOvf_q    <= outOvf_d;
    end
  end

  assign out_max      = outMax_q;
  assign out_idx      = outIdx_q;
  assign out_count    = outCount_q;
  assign out_overflow = outOvf_q;

endmodule

// File: tb/tb_single_argmax_stream.sv
// Directed bench for single_argmax_stream with N_MAX=4 so the overflow path is reachable.
module tb_single_argmax_stream;

  localparam int N_MAX = 4;
  localparam int IDX_W = 2;

  logic              clk;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_max;
  logic [IDX_W-1:0]  out_idx;
  logic [IDX_W:0]    out_count;
  logic              out_overflow;

  int testCount = 0;
  int failCount = 0;

  single_argmax_stream #(.N_MAX(N_MAX), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_max      (out_max),
    .out_idx      (out_idx),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted beat; inputs change 1ns after the edge so sampling never races the clock.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    checkOutput("in_ready_beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expMax, input logic [31:0] expIdx,
                             input logic [31:0] expCount, input logic expOvf);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_max"}, out_max, expMax);
    checkOutput({tag, "_idx"}, {30'd0, out_idx}, expIdx);
    checkOutput({tag, "_count"}, {29'd0, out_count}, expCount);
    checkOutput({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, expOvf});
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_handoff_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_handoff_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_max", out_max, 32'h0);
    checkOutput("rst_idx", {30'd0, out_idx}, 32'd0);
    checkOutput("rst_count", {29'd0, out_count}, 32'd0);
    checkOutput("rst_ovf", {31'd0, out_overflow}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // {1.0, 3.0, 2.0}: max 3.0 at index 1, result valid right after the last beat
    applyStimulus(32'h3F800000, 1'b0);
    applyStimulus(32'h40400000, 1'b0);
    checkOutput("pos_not_early", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'h40000000, 1'b1);
    checkResult("pos", 32'h40400000, 32'd1, 32'd3, 1'b0);
    handoff("pos");
    checkOutput("pos_kept_max", out_max, 32'h40400000);

    // {-2.0, -0.5, -1.0}: -0.5 wins
    applyStimulus(32'hC0000000, 1'b0);
    applyStimulus(32'hBF000000, 1'b0);
    applyStimulus(32'hBF800000, 1'b1);
    checkResult("neg", 32'hBF000000, 32'd1, 32'd3, 1'b0);
    handoff("neg");

    // {-0, +0, +0}: +0 beats -0, the tie keeps index 1
    applyStimulus(32'h80000000, 1'b0);
    applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'h00000000, 1'b1);
    checkResult("zero", 32'h00000000, 32'd1, 32'd3, 1'b0);
    handoff("zero");

    // {5.0, 5.0} then five cycles of backpressure with junk offered on the input
    applyStimulus(32'h40A00000, 1'b0);
    applyStimulus(32'h40A00000, 1'b1);
    checkResult("tie", 32'h40A00000, 32'd0, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h7F7FFFFF;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      checkResult("bp", 32'h40A00000, 32'd0, 32'd2, 1'b0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handoff("bp");

    // {1.0, 3.0, 2.0} again with random idle gaps between beats
    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      case (b)
        0:       applyStimulus(32'h3F800000, 1'b0);
        1:       applyStimulus(32'h40400000, 1'b0);
        default: applyStimulus(32'h40000000, 1'b1);
      endcase
    end
    checkResult("gap", 32'h40400000, 32'd1, 32'd3, 1'b0);
    handoff("gap");

    // Six beats with N_MAX=4: the two 9.0 beats are dropped and flag overflow
    applyStimulus(32'h3F800000, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h40400000, 1'b0);
    applyStimulus(32'h40800000, 1'b0);
    applyStimulus(32'h41100000, 1'b0);
    applyStimulus(32'h41100000, 1'b1);
    checkResult("ovf", 32'h40800000, 32'd3, 32'd4, 1'b1);
    handoff("ovf");

    applyStimulus(32'h40000000, 1'b1);
    checkResult("post_ovf", 32'h40000000, 32'd0, 32'd1, 1'b0);
    handoff("post_ovf");

    // Reset in the middle of {7.0, 8.0} discards the partial vector
    applyStimulus(32'h40E00000, 1'b0);
    applyStimulus(32'h41000000, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_max", out_max, 32'h0);
    checkOutput("midrst_count", {29'd0, out_count}, 32'd0);
    applyStimulus(32'h3F800000, 1'b1);
    checkResult("midrst", 32'h3F800000, 32'd0, 32'd1, 1'b0);
    handoff("midrst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
